// File: rtl/instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage ahead of main_control_unit. Holds the PC, issues
//               one word read at a time to instruction memory, buffers the
//               returned words in a small FIFO and presents each one to
//               decode with pre-sliced fields over a valid/ready handshake.
//               PC redirects flush buffered and in-flight instructions.
// Ports       : clk, rst             - clock, async active-high reset
//               imem_req_*           - fetch request (valid/ready, addr)
//               imem_rsp_*           - in-order read response
//               redirect_valid/pc    - branch/jump target pulse
//               dec_valid/ready      - decode handshake
//               dec_pc/instr/fields  - head-of-buffer instruction
// Revision    : 1.0 - initial release
//============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [6:0]  dec_opcode,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2
);

    localparam int                 c_PTR_W   = $clog2(BUF_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(BUF_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic [31:0]        r_buf_pc    [BUF_DEPTH];
    logic [31:0]        r_buf_instr [BUF_DEPTH];

    logic w_req_valid;
    logic w_fire;
    logic w_push;
    logic w_pop;
    logic w_dec_valid;

    // Only one request is ever outstanding and requests are issued solely
    // from REQ, so a free slot in the buffer is enough to guarantee the
    // response will have somewhere to land.
    assign w_req_valid = (r_state == S_REQ) && (r_count < c_DEPTH);
    assign w_fire      = w_req_valid && imem_req_ready;
    // A response coinciding with a redirect belongs to the old path.
    assign w_push      = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_dec_valid = (r_count != '0);
    assign w_pop       = w_dec_valid && dec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            // An instruction popped this cycle still counts as delivered;
            // everything else in the buffer is discarded.
            r_pc    <= redirect_pc & ~32'h3;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            case (r_state)
                S_WAIT:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                // A request accepted this cycle is now stale and in flight.
                S_REQ:   r_state <= w_fire ? S_DROP : S_REQ;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_fire) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
            endcase

            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Buffer storage needs no reset: entries are only observed while
    // counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wptr]    <= r_req_pc;
            r_buf_instr[r_wptr] <= imem_rsp_data;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = w_req_valid ? r_pc : 32'h0;

    assign dec_valid  = w_dec_valid;
    assign dec_pc     = w_dec_valid ? r_buf_pc[r_rptr]    : 32'h0;
    assign dec_instr  = w_dec_valid ? r_buf_instr[r_rptr] : 32'h0;
    assign dec_opcode = dec_instr[6:0];
    assign dec_funct3 = dec_instr[14:12];
    assign dec_funct7 = dec_instr[31:25];
    assign dec_rd     = dec_instr[11:7];
    assign dec_rs1    = dec_instr[19:15];
    assign dec_rs2    = dec_instr[24:20];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit. Directed scenarios
//               push expected {pc, instr} pairs; a monitor pops and compares
//               on every decode handshake. A second instance with a
//               wrapping reset PC checks address wrap-around.
// Revision    : 1.0 - initial release
//============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;

    logic        req2_valid;
    logic [31:0] req2_addr;
    logic        rsp2_valid;
    logic [31:0] rsp2_data;
    logic        dec2_valid;
    logic [31:0] dec2_pc;
    logic [31:0] dec2_instr;
    logic [6:0]  dec2_opcode;
    logic [2:0]  dec2_funct3;
    logic [6:0]  dec2_funct7;
    logic [4:0]  dec2_rd;
    logic [4:0]  dec2_rs1;
    logic [4:0]  dec2_rs2;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_opcode(dec_opcode),
        .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req2_valid), .imem_req_addr(req2_addr),
        .imem_req_ready(1'b1),
        .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .dec_valid(dec2_valid), .dec_ready(1'b1),
        .dec_pc(dec2_pc), .dec_instr(dec2_instr), .dec_opcode(dec2_opcode),
        .dec_funct3(dec2_funct3), .dec_funct7(dec2_funct7),
        .dec_rd(dec2_rd), .dec_rs1(dec2_rs1), .dec_rs2(dec2_rs2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    exp_t m_e;
    exp_t m_e2;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat = 1;

    // Memory content: address bits folded into the fields so each field
    // slice is distinguishable; address 0 reads as 32'h0000_0013 (addi).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[8:2], a[6:2], a[6:2], a[4:2], a[6:2], 7'h13};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: actual %0d entries undelivered required 0", name, q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Main memory: one outstanding request, response 'lat' cycles later.
    logic        m_pend;
    logic [31:0] m_addr;
    int          m_cnt;
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        m_pend = 1'b0; m_addr = 32'h0; m_cnt = 0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(m_addr);
                    m_pend = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                m_pend = 1'b1;
                m_addr = imem_req_addr;
                m_cnt  = lat - 1;
            end
        end
    end

    // Memory for the wrap instance: fixed one-cycle response.
    logic        r2_pend;
    logic [31:0] r2_addr;
    initial begin
        rsp2_valid = 1'b0; rsp2_data = 32'h0; r2_pend = 1'b0; r2_addr = 32'h0;
        forever begin
            @(negedge clk);
            rsp2_valid = r2_pend;
            rsp2_data  = mem_word(r2_addr);
            r2_pend    = req2_valid;
            r2_addr    = req2_addr;
        end
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_dec: actual pc %h required no delivery", dec_pc);
            end else begin
                m_e = q.pop_front();
                check32("dec_pc",     dec_pc,              m_e.pc);
                check32("dec_instr",  dec_instr,           m_e.instr);
                check32("dec_opcode", {25'h0, dec_opcode}, {25'h0, m_e.instr[6:0]});
                check32("dec_funct3", {29'h0, dec_funct3}, {29'h0, m_e.instr[14:12]});
                check32("dec_funct7", {25'h0, dec_funct7}, {25'h0, m_e.instr[31:25]});
                check32("dec_rd",     {27'h0, dec_rd},     {27'h0, m_e.instr[11:7]});
                check32("dec_rs1",    {27'h0, dec_rs1},    {27'h0, m_e.instr[19:15]});
                check32("dec_rs2",    {27'h0, dec_rs2},    {27'h0, m_e.instr[24:20]});
            end
        end
    end

    // Monitor for the wrap instance: only its first deliveries matter.
    always @(negedge clk) begin
        if (!rst && dec2_valid && q2.size() != 0) begin
            m_e2 = q2.pop_front();
            check32("wrap_dec_pc",    dec2_pc,    m_e2.pc);
            check32("wrap_dec_instr", dec2_instr, m_e2.instr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; dec_ready = 1'b0; lat = 1;
        q2.push_back(mk(32'hFFFF_FFFC));
        q2.push_back(mk(32'h0000_0000));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check32("rst_req_addr",  imem_req_addr,           32'h0);
        check32("rst_dec_valid", {31'h0, dec_valid},      32'h0);
        check32("rst_dec_pc",    dec_pc,                  32'h0);
        check32("rst_dec_instr", dec_instr,               32'h0);

        // Streaming fetch with 1-cycle memory.
        @(posedge clk); #1;
        rst = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) q.push_back(mk(32'(i * 4)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("t1_dec_valid_early", {31'h0, dec_valid}, 32'h0);
        end
        @(negedge clk);
        check32("t1_dec_valid_first", {31'h0, dec_valid}, 32'h1);
        wait_empty("t1_stream", 100);
        @(posedge clk); #1;
        dec_ready = 1'b0;
        check32("wrap_all_delivered", 32'(q2.size()), 32'h0);

        // Back-pressure: buffer fills to two entries and holds.
        do_reset();
        for (int i = 0; i < 4; i++) q.push_back(mk(32'(i * 4)));
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check32("t2_req_gated", {31'h0, imem_req_valid}, 32'h0);
            check32("t2_dec_valid", {31'h0, dec_valid},      32'h1);
            check32("t2_hold_pc",   dec_pc,                  32'h0);
            check32("t2_hold_inst", dec_instr,               32'h0000_0013);
            @(negedge clk);
        end
        @(posedge clk); #1;
        dec_ready = 1'b1;
        n = 0;
        while (!imem_req_valid && n < 20) begin @(negedge clk); n++; end
        check32("t2_resume_addr", imem_req_addr, 32'h0000_0008);
        wait_empty("t2_drain", 100);
        @(posedge clk); #1;
        dec_ready = 1'b0;

        // Redirect while waiting on a slow response.
        lat = 3;
        do_reset();
        dec_ready = 1'b1;
        q.push_back(mk(32'h0000_0100));
        q.push_back(mk(32'h0000_0104));
        n = 0;
        while (!(imem_req_valid && imem_req_ready) && n < 20) begin @(negedge clk); n++; end
        check32("t3_first_addr", imem_req_addr, 32'h0);
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check32("t3_drop_noreq", {31'h0, imem_req_valid}, 32'h0);
        check32("t3_drop_nodec", {31'h0, dec_valid},      32'h0);
        n = 0;
        while (!imem_req_valid && n < 20) begin @(negedge clk); n++; end
        check32("t3_redirect_addr", imem_req_addr, 32'h0000_0100);
        wait_empty("t3_redirect", 100);
        @(posedge clk); #1;
        dec_ready = 1'b0;

        // Redirect, response and decode handshake in the same cycle.
        lat = 1;
        do_reset();
        q.push_back(mk(32'h0000_0000));
        q.push_back(mk(32'h0000_0200));
        q.push_back(mk(32'h0000_0204));
        n = 0;
        while (!(dec_valid && imem_req_valid && imem_req_ready) && n < 20) begin
            @(negedge clk); n++;
        end
        check32("t4_setup_pc", dec_pc, 32'h0);
        @(posedge clk); #1;
        dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check32("t4_no_stale", {31'h0, dec_valid}, 32'h0);
        wait_empty("t4_redirect", 100);
        @(posedge clk); #1;
        dec_ready = 1'b0;

        // Reset pulse in the middle of WAIT; late response must be ignored.
        lat = 3;
        do_reset();
        dec_ready = 1'b1;
        n = 0;
        while (!(imem_req_valid && imem_req_ready) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.push_back(mk(32'h0000_0000));
        q.push_back(mk(32'h0000_0004));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("t6_no_dec", {31'h0, dec_valid}, 32'h0);
            if (imem_req_valid && !seen) begin
                seen = 1'b1;
                check32("t6_restart_addr", imem_req_addr, 32'h0);
            end
        end
        wait_empty("t6_restart", 100);

        check32("sb_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
